blob_bbox_accum: RTL and testbench

Streaming stage directly downstream of the connected-component labeler in the skin-detection pipeline. Consumes one label per pixel in raster order for a 320x240 frame and accumulates, per label, bounding box (xmin/xmax/ymin/ymax) and pixel area in an on-chip table. At frame end, scans the table and emits one record per non-empty label over a valid/ready interface for the hand/face region selector. Label 0 is background and is never accumulated.

---
 rtl/blob_pkg.sv | 45 ++++
 rtl/blob_table_ram.sv | 38 +++
 rtl/blob_bbox_accum.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_blob_bbox_accum.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// ---------------------------------------------------------------------------
// blob_pkg
// Shared types and constants for the blob bounding-box accumulator.
//   entry_t     : one table entry (bounding box + pixel area)
//   state_t     : accumulator FSM states
//   EMPTY_ENTRY : value written to every address during CLEAR. The min
//                 fields start at all-ones and the max fields at zero, so
//                 the first pixel of a label sets all four bounds.
// Optional feature macro used by the top level: BLOB_MIN_AREA_EN.
// ---------------------------------------------------------------------------
package blob_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int LABEL_W   = 8;
    localparam int COORD_W   = 9;
    localparam int AREA_W    = 17;
    localparam int DEPTH     = 1 << LABEL_W;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic [AREA_W-1:0]  area;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    localparam entry_t EMPTY_ENTRY = '{
        xmin: {COORD_W{1'b1}},
        xmax: {COORD_W{1'b0}},
        ymin: {COORD_W{1'b1}},
        ymax: {COORD_W{1'b0}},
        area: {AREA_W{1'b0}}
    };

endpackage

// File: rtl/blob_table_ram.sv
// ---------------------------------------------------------------------------
// blob_table_ram
// Simple dual-port label table: DEPTH x entry_t, one write port and one read
// port with a registered (1-cycle) read. A read and a write to the same
// address in the same cycle return the OLD contents; the top level forwards
// around this.
// Ports:
//   i_clk    : clock, rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (sampled every cycle)
//   o_rdata  : read data, valid one cycle after i_raddr
// ---------------------------------------------------------------------------
module blob_table_ram
    import blob_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [LABEL_W-1:0] i_waddr,
    input  entry_t             i_wdata,
    input  logic [LABEL_W-1:0] i_raddr,
    output entry_t             o_rdata
);

    entry_t r_mem [DEPTH];
    entry_t r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/blob_bbox_accum.sv
// ---------------------------------------------------------------------------
// blob_bbox_accum
// Accumulates per-label bounding box and area from a raster stream of
// connected-component labels, then dumps one record per non-empty label.
// Label 0 is background and never accumulated.
//
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   in_valid/ready  : label beat handshake (transfer when both high)
//   in_label        : pixel label, 0 = background
//   in_sof          : beat is pixel (0,0); forces the position counters
//   out_valid/ready : record handshake (transfer when both high; record
//                     held stable while out_valid && !out_ready)
//   out_label       : record label (0 only for the empty-frame record)
//   out_xmin/xmax   : bounding-box columns
//   out_ymin/ymax   : bounding-box rows
//   out_area        : pixel count, saturating
//   out_last        : final record of the frame
//   busy            : high in CLEAR, DRAIN and DUMP
//
// Configuration macro BLOB_MIN_AREA_EN: when defined, the dump also drops
// entries whose area is below the MIN_AREA parameter.
// ---------------------------------------------------------------------------
module blob_bbox_accum
    import blob_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
`ifdef BLOB_MIN_AREA_EN
    ,
    parameter int MIN_AREA = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [COORD_W-1:0] out_xmin,
    output logic [COORD_W-1:0] out_xmax,
    output logic [COORD_W-1:0] out_ymin,
    output logic [COORD_W-1:0] out_ymax,
    output logic [AREA_W-1:0]  out_area,
    output logic               out_last,
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(IMG_H - 1);
    localparam logic [LABEL_W:0]   SCAN_FIRST = (LABEL_W+1)'(1);

    // ------------------------------------------------------------------
    // FSM and table-port signals
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next;
    logic [LABEL_W-1:0] r_clr_addr;

    logic               w_we;
    logic [LABEL_W-1:0] w_waddr;
    entry_t             w_wdata;
    logic [LABEL_W-1:0] w_raddr;
    entry_t             w_rdata;

    // ------------------------------------------------------------------
    // Accumulate pipeline: s1 = RAM data returning, s2 = write-back,
    // s3 = entry written last cycle (RAM read of that cycle saw old data)
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] r_x, r_y;
    logic [COORD_W-1:0] w_px, w_py;
    logic               w_accept;
    logic               w_last_px;

    logic               r_s1_valid;
    logic [LABEL_W-1:0] r_s1_label;
    logic [COORD_W-1:0] r_s1_x, r_s1_y;

    logic               r_s2_valid;
    logic [LABEL_W-1:0] r_s2_label;
    entry_t             r_s2_entry;

    logic               r_s3_valid;
    logic [LABEL_W-1:0] r_s3_label;
    entry_t             r_s3_entry;

    entry_t             w_base;
    entry_t             w_upd;

    // ------------------------------------------------------------------
    // Dump path
    // ------------------------------------------------------------------
    logic [LABEL_W:0]   r_scan_addr;   // MSB set = scan finished
    logic               r_rd_pend;
    logic [LABEL_W-1:0] r_rd_label;
    logic               r_hold_valid;
    logic [LABEL_W-1:0] r_hold_label;
    entry_t             r_hold_entry;
    logic               r_final_sent;

    logic               r_out_valid;
    logic [LABEL_W-1:0] r_out_label;
    entry_t             r_out_entry;
    logic               r_out_last;

    logic               w_issue;
    logic               w_qual;
    logic               w_final;
    logic               w_out_fire;
    logic               w_push_hold;

    // ------------------------------------------------------------------
    // Table RAM
    // ------------------------------------------------------------------
    blob_table_ram u_table (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_next;
            // Counter idles at 0 so every CLEAR pass starts at address 0.
            r_clr_addr <= (r_state == ST_CLEAR) ? r_clr_addr + 1'b1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, handshake flags, table port muxing
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        w_we     = 1'b0;
        w_waddr  = r_s2_label;
        w_wdata  = r_s2_entry;
        w_raddr  = in_label;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = EMPTY_ENTRY;
                if (r_clr_addr == {LABEL_W{1'b1}}) begin
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_we     = r_s2_valid;
                if (in_valid && w_last_px) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_we = r_s2_valid;
                if (!r_s1_valid && !r_s2_valid) begin
                    w_next = ST_DUMP;
                end
            end
            ST_DUMP: begin
                w_raddr = r_scan_addr[LABEL_W-1:0];
                if (w_out_fire && r_out_last) begin
                    w_next = ST_CLEAR;
                end
            end
            default: begin
                w_next = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate datapath
    // ------------------------------------------------------------------
    assign w_accept  = in_valid && in_ready;
    assign w_px      = in_sof ? '0 : r_x;
    assign w_py      = in_sof ? '0 : r_y;
    assign w_last_px = (w_px == X_LAST) && (w_py == Y_LAST);

    // Newest copy of the entry wins: write stage, then last write, then RAM.
    always_comb begin
        w_base = w_rdata;
        if (r_s2_valid && (r_s2_label == r_s1_label)) begin
            w_base = r_s2_entry;
        end else if (r_s3_valid && (r_s3_label == r_s1_label)) begin
            w_base = r_s3_entry;
        end
        w_upd = w_base;
        if (r_s1_x < w_base.xmin) w_upd.xmin = r_s1_x;
        if (r_s1_x > w_base.xmax) w_upd.xmax = r_s1_x;
        if (r_s1_y < w_base.ymin) w_upd.ymin = r_s1_y;
        if (r_s1_y > w_base.ymax) w_upd.ymax = r_s1_y;
        if (w_base.area != {AREA_W{1'b1}}) begin
            w_upd.area = w_base.area + AREA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_label <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_label <= '0;
            r_s2_entry <= EMPTY_ENTRY;
            r_s3_valid <= 1'b0;
            r_s3_label <= '0;
            r_s3_entry <= EMPTY_ENTRY;
        end else begin
            r_s1_valid <= w_accept && (in_label != '0);
            r_s1_label <= in_label;
            r_s1_x     <= w_px;
            r_s1_y     <= w_py;
            r_s2_valid <= r_s1_valid;
            r_s2_label <= r_s1_label;
            r_s2_entry <= w_upd;
            r_s3_valid <= r_s2_valid;
            r_s3_label <= r_s2_label;
            r_s3_entry <= r_s2_entry;

            if (r_state == ST_CLEAR) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_accept) begin
                if (w_px == X_LAST) begin
                    r_x <= '0;
                    r_y <= (w_py == Y_LAST) ? '0 : w_py + 1'b1;
                end else begin
                    r_x <= w_px + 1'b1;
                    r_y <= w_py;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Dump datapath
    // One read outstanding at a time. A qualifying entry goes to the hold
    // register; it is only moved to the output when a later qualifying
    // entry shows up (so it is not last) or the scan ends (so it is last).
    // A read is issued only when its result can be absorbed: hold empty,
    // or output register free for the hold to move into.
    // ------------------------------------------------------------------
`ifdef BLOB_MIN_AREA_EN
    assign w_qual = (w_rdata.area != '0) && (w_rdata.area >= AREA_W'(MIN_AREA));
`else
    assign w_qual = (w_rdata.area != '0);
`endif

    assign w_out_fire  = r_out_valid && out_ready;
    assign w_issue     = (r_state == ST_DUMP) && !r_scan_addr[LABEL_W] && !r_rd_pend
                         && (!r_hold_valid || !r_out_valid);
    assign w_push_hold = (r_state == ST_DUMP) && r_rd_pend && w_qual && r_hold_valid;
    assign w_final     = (r_state == ST_DUMP) && r_scan_addr[LABEL_W] && !r_rd_pend
                         && !r_final_sent && !r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_addr  <= SCAN_FIRST;
            r_rd_pend    <= 1'b0;
            r_rd_label   <= '0;
            r_hold_valid <= 1'b0;
            r_hold_label <= '0;
            r_hold_entry <= '0;
            r_final_sent <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_label  <= '0;
            r_out_entry  <= '0;
            r_out_last   <= 1'b0;
        end else begin
            if (r_state != ST_DUMP) begin
                r_scan_addr  <= SCAN_FIRST;
                r_rd_pend    <= 1'b0;
                r_hold_valid <= 1'b0;
                r_final_sent <= 1'b0;
            end else begin
                r_rd_pend <= w_issue;
                if (w_issue) begin
                    r_rd_label  <= r_scan_addr[LABEL_W-1:0];
                    r_scan_addr <= r_scan_addr + 1'b1;
                end
                if (r_rd_pend && w_qual) begin
                    r_hold_valid <= 1'b1;
                    r_hold_label <= r_rd_label;
                    r_hold_entry <= w_rdata;
                end
                if (w_final) begin
                    r_final_sent <= 1'b1;
                    r_hold_valid <= 1'b0;
                end
            end

            if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            // Loads only happen with the output register empty.
            if (w_push_hold) begin
                r_out_valid <= 1'b1;
                r_out_label <= r_hold_label;
                r_out_entry <= r_hold_entry;
                r_out_last  <= 1'b0;
            end else if (w_final) begin
                r_out_valid <= 1'b1;
                r_out_label <= r_hold_valid ? r_hold_label : '0;
                r_out_entry <= r_hold_valid ? r_hold_entry : '0;
                r_out_last  <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_label = r_out_label;
    assign out_xmin  = r_out_entry.xmin;
    assign out_xmax  = r_out_entry.xmax;
    assign out_ymin  = r_out_entry.ymin;
    assign out_ymax  = r_out_entry.ymax;
    assign out_area  = r_out_entry.area;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_blob_bbox_accum.sv
// ---------------------------------------------------------------------------
// tb_blob_bbox_accum
// Directed bench for blob_bbox_accum on a reduced 128x24 frame. Expected
// records are pushed to exp_q when a frame is prepared and popped as the
// DUT hands records over. Honours BLOB_MIN_AREA_EN (MIN_AREA = 4).
// ---------------------------------------------------------------------------
module tb_blob_bbox_accum;
    import blob_pkg::*;

    localparam int TW          = 128;
    localparam int TH          = 24;
    localparam int NPIX        = TW * TH;
    localparam int TB_MIN_AREA = 4;
    localparam int RW          = LABEL_W + 4 * COORD_W + AREA_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [LABEL_W-1:0] in_label  = '0;
    logic               in_sof    = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [LABEL_W-1:0] out_label;
    logic [COORD_W-1:0] out_xmin, out_xmax, out_ymin, out_ymax;
    logic [AREA_W-1:0]  out_area;
    logic               out_last;
    logic               busy;

    blob_bbox_accum #(
        .IMG_W (TW),
        .IMG_H (TH)
`ifdef BLOB_MIN_AREA_EN
        ,
        .MIN_AREA (TB_MIN_AREA)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_label  (in_label),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_label (out_label),
        .out_xmin  (out_xmin),
        .out_xmax  (out_xmax),
        .out_ymin  (out_ymin),
        .out_ymax  (out_ymax),
        .out_area  (out_area),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_err    = 0;
    logic [RW-1:0]    exp_q[$];
    logic [LABEL_W-1:0] frame_mem [NPIX];

    function automatic logic [RW-1:0] pack_rec(input int l, input int xmn, input int xmx,
                                               input int ymn, input int ymx, input int ar,
                                               input logic last);
        pack_rec = {LABEL_W'(l), COORD_W'(xmn), COORD_W'(xmx), COORD_W'(ymn),
                    COORD_W'(ymx), AREA_W'(ar), last};
    endfunction

    function automatic logic [RW-1:0] observed();
        observed = {out_label, out_xmin, out_xmax, out_ymin, out_ymax, out_area, out_last};
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < NPIX; i++) frame_mem[i] = '0;
    endtask

    task automatic set_pix(input int x, input int y, input int l);
        frame_mem[y * TW + x] = LABEL_W'(l);
    endtask

    task automatic apply_reset(input string tag);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_label  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_rst_in_ready"},  RW'(in_ready),  RW'(0));
        chk({tag, "_rst_out_valid"}, RW'(out_valid), RW'(0));
        chk({tag, "_rst_busy"},      RW'(busy),      RW'(1));
        chk({tag, "_rst_out_data"},  observed(),     RW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Counts cycles with in_ready low; a full CLEAR is 256 of them.
    task automatic wait_clear(input string tag);
        int   n        = 0;
        logic busy_bad = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            if (in_ready) break;
            if (!busy) busy_bad = 1'b1;
            n++;
        end
        chk({tag, "_clear_cycles"},  RW'(n),        RW'(256));
        chk({tag, "_busy_at_ready"}, RW'(busy),     RW'(0));
        chk({tag, "_busy_in_clear"}, RW'(busy_bad), RW'(0));
    endtask

    task automatic drive_beats(input string tag, input int nbeats);
        int   i     = 0;
        int   guard = 0;
        logic rdy;
        while (i < nbeats && guard < nbeats + 500) begin
            in_valid = 1'b1;
            in_label = frame_mem[i];
            in_sof   = (i == 0);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (rdy) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_label = '0;
        chk({tag, "_beats_accepted"}, RW'(i),     RW'(nbeats));
        chk({tag, "_no_stall"},       RW'(guard), RW'(nbeats));
    endtask

    task automatic run_frame(input string tag, input int stall_cycles);
        int            cycles  = 0;
        int            stalled = 0;
        logic          done    = 1'b0;
        logic [RW-1:0] obs;
        drive_beats(tag, NPIX);
        chk({tag, "_ready_low_after_last"}, RW'(in_ready), RW'(0));
        chk({tag, "_busy_after_last"},      RW'(busy),     RW'(1));
        out_ready = (stall_cycles == 0);
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                obs = observed();
                if (!out_ready && stalled >= stall_cycles) out_ready = 1'b1;
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL %s_extra_record observed=%h expected=none", tag, obs);
                    done = 1'b1;
                end
                if (exp_q.size() != 0) begin
                    chk({tag, "_record"}, obs, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (out_last) done = 1'b1;
                    end else begin
                        stalled++;
                    end
                end
            end
        end
        chk({tag, "_last_seen"},   RW'(done),          RW'(1));
        chk({tag, "_queue_empty"}, RW'(exp_q.size()),  RW'(0));
        chk({tag, "_stall_cycles"}, RW'(stalled),      RW'(stall_cycles));
        exp_q.delete();
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_clear(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        apply_reset("por");
        wait_clear("por");

        // Reset in the middle of ACCUM: label 9 must not survive.
        for (int i = 0; i < NPIX; i++) frame_mem[i] = 8'd9;
        drive_beats("mid", 500);
        chk("mid_busy_accum", RW'(busy), RW'(0));
        apply_reset("mid");
        wait_clear("mid");

        // Single pixel.
        clear_mem();
        set_pix(10, 20, 5);
        exp_q.push_back(pack_rec(5, 10, 10, 20, 20, 1, 1'b1));
        run_frame("single", 0);

        // Back-to-back same label.
        clear_mem();
        for (int x = 0; x < 100; x++) set_pix(x, 0, 3);
        exp_q.push_back(pack_rec(3, 0, 99, 0, 0, 100, 1'b1));
        run_frame("row", 0);

        // Alternating labels: same label two beats apart.
        clear_mem();
        for (int x = 0; x < 40; x++) set_pix(x, 5, (x % 2 == 0) ? 4 : 6);
        exp_q.push_back(pack_rec(4, 0, 38, 5, 5, 20, 1'b0));
        exp_q.push_back(pack_rec(6, 1, 39, 5, 5, 20, 1'b1));
        run_frame("alt", 0);

        // All background.
        clear_mem();
        exp_q.push_back(pack_rec(0, 0, 0, 0, 0, 0, 1'b1));
        run_frame("empty", 0);

        // Two labels, consumer stalls 50 cycles on the first record.
        clear_mem();
        for (int y = 2; y <= 3; y++)
            for (int x = 5; x <= 7; x++) set_pix(x, y, 2);
        set_pix(100, 10, 7);
        set_pix(90, 11, 7);
        set_pix(101, 12, 7);
        exp_q.push_back(pack_rec(2, 5, 7, 2, 3, 6, 1'b0));
        exp_q.push_back(pack_rec(7, 90, 101, 10, 12, 3, 1'b1));
        run_frame("stall", 50);

        // Area threshold: label 1 area 3, label 2 area 4.
        clear_mem();
        for (int x = 0; x <= 2; x++) set_pix(x, 1, 1);
        for (int y = 4; y <= 5; y++)
            for (int x = 10; x <= 11; x++) set_pix(x, y, 2);
`ifdef BLOB_MIN_AREA_EN
        exp_q.push_back(pack_rec(2, 10, 11, 4, 5, 4, 1'b1));
`else
        exp_q.push_back(pack_rec(1, 0, 2, 1, 1, 3, 1'b0));
        exp_q.push_back(pack_rec(2, 10, 11, 4, 5, 4, 1'b1));
`endif
        run_frame("minarea", 0);

        // Frame corners, including the final pixel.
        clear_mem();
        set_pix(0, 0, 200);
        set_pix(TW - 1, TH - 1, 200);
        exp_q.push_back(pack_rec(200, 0, TW - 1, 0, TH - 1, 2, 1'b1));
        run_frame("corner", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
